// File: rtl/memory_access_if.sv
// memory_access_if: data-memory bus between the load/store stage and the memory.
//   Request channel : mem_o_req_valid / mem_i_req_ready with mem_o_addr,
//                     mem_o_wen, mem_o_wdata, mem_o_wstrb
//   Response channel: mem_i_resp_valid / mem_o_resp_ready with mem_i_rdata
//   master modport  : the load/store stage (memory_access)
//   slave modport   : the memory / bus fabric
interface memory_access_if;
    logic        mem_o_req_valid;
    logic        mem_i_req_ready;
    logic [31:0] mem_o_addr;
    logic        mem_o_wen;
    logic [31:0] mem_o_wdata;
    logic [3:0]  mem_o_wstrb;
    logic        mem_i_resp_valid;
    logic [31:0] mem_i_rdata;
    logic        mem_o_resp_ready;

    modport master (
        output mem_o_req_valid, mem_o_addr, mem_o_wen, mem_o_wdata, mem_o_wstrb,
               mem_o_resp_ready,
        input  mem_i_req_ready, mem_i_resp_valid, mem_i_rdata
    );

    modport slave (
        input  mem_o_req_valid, mem_o_addr, mem_o_wen, mem_o_wdata, mem_o_wstrb,
               mem_o_resp_ready,
        output mem_i_req_ready, mem_i_resp_valid, mem_i_rdata
    );
endinterface

// File: rtl/memory_access.sv
// memory_access: multi-cycle load/store stage between execute and write-back.
// Takes one instruction from execute, runs a valid/ready request + response
// on the data-memory bus, aligns/extends load data and emits a one-cycle
// commit pulse with the load result (valM) and an abort flag (err).
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   execute_i_valid       instruction valid from execute (held until accepted)
//   memory_o_ready        stage idle, accepts execute_i_valid this cycle
//   execute_i_valE        effective address / ALU result
//   decode_i_valB         store data
//   decode_i_mem_ren/wen  load / store
//   decode_i_mem_size     00 byte, 01 half, 1x word
//   decode_i_mem_unsigned zero-extend loads
//   mem                   data-memory bus (memory_access_if.master)
//   memory_o_valM         aligned/extended load data (0 for stores/ALU ops)
//   memory_o_commit       one-cycle pulse when the instruction finishes
//   memory_o_err          qualifies commit: timeout or misalign abort
//
// Parameter TIMEOUT_CYCLES (1..65535): cycles allowed in REQ+RESP before abort.
// Optional macro MEM_ACCESS_MISALIGN_CHECK_EN: reject misaligned half/word
// accesses at capture without touching the bus.
//
// state | meaning
// IDLE  | waiting for execute_i_valid
// REQ   | bus request outstanding
// RESP  | request accepted, waiting for response
// DONE  | commit pulse
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   execute_i_valid,
    output logic                   memory_o_ready,
    input  logic [31:0]            execute_i_valE,
    input  logic [31:0]            decode_i_valB,
    input  logic                   decode_i_mem_ren,
    input  logic                   decode_i_mem_wen,
    input  logic [1:0]             decode_i_mem_size,
    input  logic                   decode_i_mem_unsigned,
    memory_access_if.master        mem,
    output logic [31:0]            memory_o_valM,
    output logic                   memory_o_commit,
    output logic                   memory_o_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state, state_nxt;
    logic        abort;
    logic [15:0] cnt;
    logic [31:0] addr_q, wdata_q, valm_q;
    logic [3:0]  wstrb_q;
    logic        wen_q, ren_q, uns_q, err_q;
    logic [1:0]  size_q, offs_q;

    logic        capture, is_mem, misalign;
    logic [31:0] st_wdata, ld_data, ld_shift_b, ld_shift_h;
    logic [3:0]  st_wstrb;

    assign capture = (state == IDLE) && execute_i_valid;
    assign is_mem  = decode_i_mem_ren | decode_i_mem_wen;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign misalign = is_mem &&
                      (((decode_i_mem_size == 2'b01) && execute_i_valE[0]) ||
                       (decode_i_mem_size[1] && (execute_i_valE[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A handshake completing in the last allowed cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: if (execute_i_valid) state_nxt = (is_mem && !misalign) ? REQ : DONE;
            REQ: begin
                if (mem.mem_i_req_ready) state_nxt = RESP;
                else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    abort     = 1'b1;
                end
            end
            RESP: begin
                if (mem.mem_i_resp_valid) state_nxt = DONE;
                else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    abort     = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        st_wdata = decode_i_valB;
        st_wstrb = 4'b1111;
        case (decode_i_mem_size)
            2'b00: begin
                st_wdata = {4{decode_i_valB[7:0]}};
                st_wstrb = 4'b0001 << execute_i_valE[1:0];
            end
            2'b01: begin
                st_wdata = {2{decode_i_valB[15:0]}};
                st_wstrb = 4'b0011 << {execute_i_valE[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign ld_shift_b = mem.mem_i_rdata >> {offs_q, 3'b000};
    assign ld_shift_h = mem.mem_i_rdata >> {offs_q[1], 4'b0000};

    always_comb begin
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & ld_shift_b[7]}}, ld_shift_b[7:0]};
            2'b01:   ld_data = {{16{~uns_q & ld_shift_h[15]}}, ld_shift_h[15:0]};
            default: ld_data = mem.mem_i_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            offs_q  <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else if (capture) begin
            cnt     <= '0;
            addr_q  <= {execute_i_valE[31:2], 2'b00};
            wdata_q <= st_wdata;
            wstrb_q <= decode_i_mem_wen ? st_wstrb : 4'b0000;
            wen_q   <= decode_i_mem_wen;
            ren_q   <= decode_i_mem_ren;
            uns_q   <= decode_i_mem_unsigned;
            size_q  <= decode_i_mem_size;
            offs_q  <= execute_i_valE[1:0];
            valm_q  <= '0;
            err_q   <= misalign;
        end else if ((state == REQ) || (state == RESP)) begin
            cnt <= cnt + 16'd1;
            if ((state == RESP) && mem.mem_i_resp_valid) begin
                valm_q <= ren_q ? ld_data : 32'd0;
            end else if (abort) begin
                valm_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign memory_o_ready       = (state == IDLE);
    assign memory_o_commit      = (state == DONE);
    assign memory_o_valM        = valm_q;
    assign memory_o_err         = err_q;
    assign mem.mem_o_req_valid  = (state == REQ);
    assign mem.mem_o_resp_ready = (state == RESP);
    assign mem.mem_o_addr       = addr_q;
    assign mem.mem_o_wen        = wen_q;
    assign mem.mem_o_wdata      = wdata_q;
    assign mem.mem_o_wstrb      = wstrb_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    localparam int T = 8;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        execute_i_valid;
    logic        memory_o_ready;
    logic [31:0] execute_i_valE, decode_i_valB;
    logic        decode_i_mem_ren, decode_i_mem_wen, decode_i_mem_unsigned;
    logic [1:0]  decode_i_mem_size;
    logic [31:0] memory_o_valM;
    logic        memory_o_commit, memory_o_err;

    int n_assert = 0;
    int n_fail   = 0;

    memory_access_if bus ();

    memory_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .execute_i_valid       (execute_i_valid),
        .memory_o_ready        (memory_o_ready),
        .execute_i_valE        (execute_i_valE),
        .decode_i_valB         (decode_i_valB),
        .decode_i_mem_ren      (decode_i_mem_ren),
        .decode_i_mem_wen      (decode_i_mem_wen),
        .decode_i_mem_size     (decode_i_mem_size),
        .decode_i_mem_unsigned (decode_i_mem_unsigned),
        .mem                   (bus),
        .memory_o_valM         (memory_o_valM),
        .memory_o_commit       (memory_o_commit),
        .memory_o_err          (memory_o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte lanes counted from bit 0, extension by masking.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] rd,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (32'(a[1:0]) * 8)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (32'(a[1]) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] b, input logic [1:0] sz);
        if (sz == 2'd0) return (b & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return 4'(3 << (32'(a[1]) * 2));
        return 4'hF;
    endfunction

    // Runs one instruction while acting as the bus; entered and left on a negedge.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ren, input logic wen, input logic [1:0] sz,
                         input logic uns, input int req_stall, input int resp_delay,
                         input logic [31:0] rd);
        bit          is_mem, mis, got, saw_req;
        int          lat, cyc, req_wait, resp_wait;
        logic [31:0] e_valm;
        logic        e_err;
        is_mem = ren | wen;
        mis    = MIS_EN && is_mem && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
        if (!is_mem || mis) begin
            lat = 1; e_err = mis; e_valm = 0;
        end else if (req_stall + resp_delay + 2 > T) begin
            lat = 1 + T; e_err = 1; e_valm = 0;
        end else begin
            lat = 3 + req_stall + resp_delay; e_err = 0;
            e_valm = ren ? ref_load(a, rd, sz, uns) : 32'd0;
        end
        chk({tag, "_ready_before"}, memory_o_ready, 1);
        execute_i_valid = 1; execute_i_valE = a; decode_i_valB = b;
        decode_i_mem_ren = ren; decode_i_mem_wen = wen;
        decode_i_mem_size = sz; decode_i_mem_unsigned = uns;
        @(negedge clk);
        execute_i_valid = 0; execute_i_valE = $urandom; decode_i_valB = $urandom;
        decode_i_mem_ren = 0; decode_i_mem_wen = 0;
        cyc = 1; req_wait = 0; resp_wait = 0; got = 0; saw_req = 0;
        while (cyc < 300) begin
            if (memory_o_commit) begin got = 1; break; end
            bus.mem_i_req_ready = 0; bus.mem_i_resp_valid = 0; bus.mem_i_rdata = $urandom;
            if (bus.mem_o_req_valid) begin
                saw_req = 1;
                chk({tag, "_addr"}, bus.mem_o_addr, a & 32'hFFFF_FFFC);
                chk({tag, "_wen"}, bus.mem_o_wen, wen);
                chk({tag, "_wstrb"}, bus.mem_o_wstrb, wen ? ref_wstrb(a, sz) : 4'h0);
                if (wen) chk({tag, "_wdata"}, bus.mem_o_wdata, ref_wdata(b, sz));
                if (req_wait >= req_stall) bus.mem_i_req_ready = 1;
                else req_wait++;
            end
            if (bus.mem_o_resp_ready) begin
                if (resp_wait >= resp_delay) begin
                    bus.mem_i_resp_valid = 1; bus.mem_i_rdata = rd;
                end else resp_wait++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_i_req_ready = 0; bus.mem_i_resp_valid = 0;
        chk({tag, "_commit_seen"}, got, 1);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_req_issued"}, saw_req, is_mem && !mis);
        chk({tag, "_valM"}, memory_o_valM, e_valm);
        chk({tag, "_err"}, memory_o_err, e_err);
        @(negedge clk);
        chk({tag, "_commit_pulse"}, memory_o_commit, 0);
        chk({tag, "_ready_after"}, memory_o_ready, 1);
        chk({tag, "_valM_hold"}, memory_o_valM, e_valm);
        chk({tag, "_err_hold"}, memory_o_err, e_err);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          kind;

        rst = 1; execute_i_valid = 0; execute_i_valE = 0; decode_i_valB = 0;
        decode_i_mem_ren = 0; decode_i_mem_wen = 0; decode_i_mem_size = 0;
        decode_i_mem_unsigned = 0;
        bus.mem_i_req_ready = 0; bus.mem_i_resp_valid = 0; bus.mem_i_rdata = 0;
        #1;
        chk("rst_ready", memory_o_ready, 1);
        chk("rst_commit", memory_o_commit, 0);
        chk("rst_err", memory_o_err, 0);
        chk("rst_valM", memory_o_valM, 0);
        chk("rst_req_valid", bus.mem_o_req_valid, 0);
        chk("rst_addr", bus.mem_o_addr, 0);
        chk("rst_wstrb", bus.mem_o_wstrb, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);

        do_op("lb",  32'h8000_0003, 32'h0, 1, 0, 2'd0, 0, 0, 0, 32'h80FF_1234);
        do_op("lbu", 32'h8000_0003, 32'h0, 1, 0, 2'd0, 1, 0, 0, 32'h80FF_1234);
        do_op("sh",  32'h8000_0002, 32'h0000_ABCD, 0, 1, 2'd1, 0, 0, 0, 32'h0);
        do_op("lw_stall", 32'h8000_0010, 32'h0, 1, 0, 2'd2, 0, 3, 2, 32'hDEAD_BEEF);
        do_op("to_req", 32'h8000_0020, 32'h0, 1, 0, 2'd2, 0, 1000, 0, 32'h1234_5678);
        do_op("alu_after_to", 32'h0000_1111, 32'h0, 0, 0, 2'd0, 0, 0, 0, 32'h0);
        do_op("to_resp", 32'h8000_0024, 32'h0, 1, 0, 2'd2, 0, 0, 1000, 32'h1234_5678);
        do_op("lh_hi", 32'h8000_0006, 32'h0, 1, 0, 2'd1, 0, 1, 1, 32'h9ABC_1234);
        do_op("lw_mis", 32'h8000_0002, 32'h0, 1, 0, 2'd2, 0, 0, 0, 32'hCAFE_F00D);

        // Async reset while a request is outstanding.
        execute_i_valid = 1; execute_i_valE = 32'h8000_0040;
        decode_i_mem_ren = 1; decode_i_mem_size = 2'd2;
        @(negedge clk);
        execute_i_valid = 0; decode_i_mem_ren = 0;
        chk("mid_req_valid_before", bus.mem_o_req_valid, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_req_valid", bus.mem_o_req_valid, 0);
        chk("mid_rst_ready", memory_o_ready, 1);
        chk("mid_rst_commit", memory_o_commit, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_commit", memory_o_commit, 0);
            chk("post_rst_req_valid", bus.mem_o_req_valid, 0);
        end

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            do_op($sformatf("rnd%0d", i), a, $urandom, kind == 1, kind == 2, sz,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Multi-cycle load/store stage between execute and write-back in the multi-cycle core.
- Accepts one instruction's address/store data from execute and performs a valid/ready handshake with the data-memory bus.
- Aligns and extends load data.
- Emits a one-cycle commit pulse plus load result (valM) consumed by write-back; commit gates register writes there.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before aborting with error (1..65535)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
execute_i_valid  input  1  execute result valid; held until accepted
memory_o_ready  output  1  stage idle, accepts execute_i_valid this cycle
execute_i_valE  input  32  effective address / ALU result
decode_i_valB  input  32  store data (rs2)
decode_i_mem_ren  input  1  load
decode_i_mem_wen  input  1  store (ren and wen never both 1)
decode_i_mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
decode_i_mem_unsigned  input  1  zero-extend load (LBU/LHU)
mem_o_req_valid  output  1  bus request valid
mem_i_req_ready  input  1  bus accepts request
mem_o_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_o_wen  output  1  request is a write
mem_o_wdata  output  32  replicated store data
mem_o_wstrb  output  4  byte strobes (0 for reads)
mem_i_resp_valid  input  1  bus response valid (reads and writes)
mem_i_rdata  input  32  read data
mem_o_resp_ready  output  1  stage accepts response
memory_o_valM  output  32  aligned/extended load data
memory_o_commit  output  1  one-cycle pulse: instruction finished
memory_o_err  output  1  valid with commit: timeout/misalign abort

Behaviour:
- Reset state: IDLE. All registered outputs are 0: valM, commit, err, addr, wdata, wstrb, wen, and counter.
- memory_o_ready = (state==IDLE); it is 1 during reset.
- Reset mid-operation returns the stage to IDLE immediately. Any outstanding bus transaction is abandoned; no commit is issued.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: on execute_i_valid, capture addr, valB, ren, wen, size, unsigned.
  - If ren|wen, go to REQ.
  - Otherwise go to DONE; non-memory instruction latency is 1 cycle to commit, with valM=0.
- REQ: mem_o_req_valid=1 with stable addr/wen/wdata/wstrb. On mem_i_req_ready, go to RESP.
- RESP: mem_o_resp_ready=1. On mem_i_resp_valid:
  - Load: valM <= extracted data. Store: valM <= 0.
  - Go to DONE.
  - A response in the same cycle as entry to RESP is impossible; the bus responds at least 1 cycle after acceptance.
- DONE: commit=1 for exactly one cycle, then IDLE. A new valid is accepted the cycle after DONE.
- Minimum memory op latency: capture→REQ→RESP→DONE = 3 cycles to commit with zero-wait bus.
- Store wdata: byte {4{valB[7:0]}}, half {2{valB[15:0]}}, word valB.
- Store wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Load extract:
  - Byte: rdata>>(addr[1:0]*8), low 8 bits.
  - Half: rdata>>(addr[1]*16), low 16 bits.
  - Sign-extend unless unsigned. Word: full rdata.
- Timeout: counter is cleared on leaving IDLE and increments each cycle in REQ/RESP. When it reaches TIMEOUT_CYCLES:
  - Go to DONE with err=1, valM=0.
  - req_valid/resp_ready drop.
- err is cleared on the next capture.
- valM/err hold their values after commit until the next capture.
- Without the optional feature, misaligned low address bits are ignored (half uses addr[1] only; word ignores addr[1:0]).

Optional Feature:
MEM_ACCESS_MISALIGN_CHECK_EN
- Defined: at capture, a misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) issues no bus request. It goes IDLE→DONE with err=1, valM=0, commit pulses.
- Undefined: no check; behaviour as above.

Test Plan:
- Reset mid-REQ (rst high 1 cycle, async) → req_valid drops the same cycle, state IDLE, no commit, memory_o_ready=1.
- LB addr 0x80000003, rdata 0x80FF1234, unsigned=0 → req addr 0x80000000, wstrb 0, commit on 3rd cycle after capture, valM=0xFFFFFF80. The same case with LBU gives valM=0x00000080.
- SH addr 0x80000002, valB 0x0000ABCD → wdata 0xABCDABCD, wstrb 4'b1100, wen=1; commit after write response, valM=0.
- Bus stalls: req_ready held low 3 cycles, resp 2 cycles later, LW rdata 0xDEADBEEF → req fields stable throughout, valM=0xDEADBEEF, single commit pulse.
- TIMEOUT_CYCLES=8, req_ready never asserted → commit with err=1 exactly 8 cycles after entering REQ, valM=0; the next ALU-only instruction commits 1 cycle after capture with err=0.
- With MEM_ACCESS_MISALIGN_CHECK_EN, LW addr 0x80000002 → no req_valid, commit with err=1 one cycle after capture.
